// File: rtl/my_exec_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the 16-bit lab CPU.
// Optional build macro: GPR_R0_ZERO_EN (r0 hard-wired to zero).
module my_exec_ctrl #(
  parameter int unsigned       ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_data,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [4:0]        alu_op,
  output logic              alu_cf,
  input  logic [15:0]       alu_c,
  input  logic              alu_cout,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic [15:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [2:0]        flags,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [4:0] OP_NOP  = 5'b00000, OP_HALT = 5'b00001, OP_LOAD = 5'b00010,
                         OP_STORE= 5'b00011, OP_SLL  = 5'b00100, OP_SLA  = 5'b00101,
                         OP_SRL  = 5'b00110, OP_SRA  = 5'b00111, OP_ADD  = 5'b01000,
                         OP_ADDI = 5'b01001, OP_SUB  = 5'b01010, OP_SUBI = 5'b01011,
                         OP_CMP  = 5'b01100, OP_AND  = 5'b01101, OP_OR   = 5'b01110,
                         OP_XOR  = 5'b01111, OP_LDIH = 5'b10000, OP_ADDC = 5'b10001,
                         OP_SUBC = 5'b10010, OP_LDIL = 5'b10011, OP_NOT  = 5'b10100,
                         OP_NAND = 5'b10101, OP_NOR  = 5'b10110, OP_XNOR = 5'b10111,
                         OP_JUMP = 5'b11000, OP_JMPR = 5'b11001, OP_BZ   = 5'b11010,
                         OP_BNZ  = 5'b11011, OP_BN   = 5'b11100, OP_BNN  = 5'b11101,
                         OP_BC   = 5'b11110, OP_BNC  = 5'b11111;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [15:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, c_q, c_d;
  logic [15:0]       wdata_q, wdata_d, ld_q, ld_d;
  logic              cout_q, cout_d;
  logic [2:0]        flags_q, flags_d;
  logic [15:0]       gpr_q [8];
  logic              gpr_we;
  logic [15:0]       gpr_wd;

  logic [4:0]  op;
  logic [2:0]  f_r1, f_r2, f_r3;
  logic [7:0]  imm8;
  logic [3:0]  val3;
  logic [15:0] rv1, rv2, rv3;
  logic        is_arith, is_logic, is_mem, is_br, wr_gpr, br_take;

  assign op   = ir_q[15:11];
  assign f_r1 = ir_q[10:8];
  assign f_r2 = ir_q[6:4];
  assign f_r3 = ir_q[2:0];
  assign imm8 = ir_q[7:0];
  assign val3 = ir_q[3:0];

`ifdef GPR_R0_ZERO_EN
  assign rv1 = (f_r1 == 3'd0) ? 16'h0000 : gpr_q[f_r1];
  assign rv2 = (f_r2 == 3'd0) ? 16'h0000 : gpr_q[f_r2];
  assign rv3 = (f_r3 == 3'd0) ? 16'h0000 : gpr_q[f_r3];
`else
  assign rv1 = gpr_q[f_r1];
  assign rv2 = gpr_q[f_r2];
  assign rv3 = gpr_q[f_r3];
`endif

  assign is_arith = op inside {OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP};
  assign is_logic = op inside {OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOT,
                               OP_SLL, OP_SLA, OP_SRL, OP_SRA};
  assign is_mem   = (op == OP_LOAD) || (op == OP_STORE);
  assign is_br    = op inside {OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC};
  assign wr_gpr   = !(op inside {OP_CMP, OP_STORE, OP_NOP, OP_HALT, OP_JUMP, OP_JMPR}) && !is_br;

  // Branches test the flags held before this instruction's writeback.
  always_comb begin
    br_take = 1'b0;
    case (op)
      OP_BZ:   br_take =  flags_q[2];
      OP_BNZ:  br_take = !flags_q[2];
      OP_BN:   br_take =  flags_q[1];
      OP_BNN:  br_take = !flags_q[1];
      OP_BC:   br_take =  flags_q[0];
      OP_BNC:  br_take = !flags_q[0];
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cout_d  = cout_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    flags_d = flags_q;
    gpr_we  = 1'b0;
    gpr_wd  = (op == OP_LOAD) ? ld_q : c_q;
    case (state_q)
      S_FETCH: if (imem_valid) begin
        ir_d    = imem_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        wdata_d = rv1;
        state_d = S_EXEC;
        case (op)
          OP_ADDI, OP_SUBI:                    begin a_d = rv1;     b_d = {8'h00, imm8}; end
          OP_LDIH:                             begin a_d = rv1;     b_d = {imm8, 8'h00}; end
          OP_LDIL, OP_JUMP:                    begin a_d = 16'h0;   b_d = {8'h00, imm8}; end
          OP_NOT:                              begin a_d = rv2;     b_d = 16'h0;         end
          OP_SLL, OP_SLA, OP_SRL, OP_SRA,
          OP_LOAD, OP_STORE:                   begin a_d = rv2;     b_d = {12'h000, val3}; end
          OP_JMPR, OP_BZ, OP_BNZ, OP_BN,
          OP_BNN, OP_BC, OP_BNC:               begin a_d = rv1;     b_d = {8'h00, imm8}; end
          OP_ADD, OP_SUB, OP_ADDC, OP_SUBC, OP_CMP, OP_AND, OP_OR,
          OP_XOR, OP_NAND, OP_NOR, OP_XNOR:    begin a_d = rv2;     b_d = rv3;           end
          default:                             begin a_d = 16'h0;   b_d = 16'h0;         end
        endcase
      end
      S_EXEC: begin
        c_d     = alu_c;
        cout_d  = alu_cout;
        addr_d  = alu_c[ADDR_W-1:0];
        state_d = is_mem ? S_MEM : (op == OP_HALT) ? S_HALT : S_WB;
      end
      S_MEM: if (dmem_ack) begin
        ld_d    = dmem_rdata;
        state_d = S_WB;
      end
      S_WB: begin
`ifdef GPR_R0_ZERO_EN
        gpr_we = wr_gpr && (f_r1 != 3'd0);
`else
        gpr_we = wr_gpr;
`endif
        if (is_arith)      flags_d = {c_q == 16'h0, c_q[15], cout_q};
        else if (is_logic) flags_d = {c_q == 16'h0, c_q[15], 1'b0};
        if ((op == OP_JUMP) || (op == OP_JMPR) || (is_br && br_take)) pc_d = c_q[ADDR_W-1:0];
        else                                                          pc_d = pc_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RST_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cout_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < 8; i++) gpr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      flags_q <= flags_d;
      if (gpr_we) gpr_q[f_r1] <= gpr_wd;
    end
  end

  // Handshake: a request rises and stays high until the cycle in which
  // valid/ack is sampled high; that cycle completes the transfer.
  assign imem_req   = (state_q == S_FETCH) && !rst;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM) && !rst;
  assign dmem_we    = dmem_req && (op == OP_STORE);
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op;
  assign alu_cf     = flags_q[0];
  assign flags      = flags_q;
  assign pc         = pc_q;
  assign halted     = (state_q == S_HALT) && !rst;

endmodule

// File: tb/tb_my_exec_ctrl.sv
// Self-checking bench for my_exec_ctrl: behavioural ALU, instruction vector table,
// scoreboard queue of expected operands/pc/flags, hand-written reset and r0 sequences.
module tb_my_exec_ctrl;

  localparam logic [4:0] NOP = 5'b00000, HALT = 5'b00001, LOAD = 5'b00010, STORE = 5'b00011,
                         SLL = 5'b00100, SLA  = 5'b00101, SRL  = 5'b00110, SRA   = 5'b00111,
                         ADD = 5'b01000, ADDI = 5'b01001, SUB  = 5'b01010, SUBI  = 5'b01011,
                         CMP = 5'b01100, AND_ = 5'b01101, OR_  = 5'b01110, XOR_  = 5'b01111,
                         LDIH= 5'b10000, ADDC = 5'b10001, SUBC = 5'b10010, LDIL  = 5'b10011,
                         NOT_= 5'b10100, NAND_= 5'b10101, NOR_ = 5'b10110, XNOR_ = 5'b10111,
                         JUMP= 5'b11000, JMPR = 5'b11001, BZ   = 5'b11010, BNZ   = 5'b11011,
                         BN  = 5'b11100, BNN  = 5'b11101, BC   = 5'b11110, BNC   = 5'b11111;

  logic        clk, rst;
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr, dmem_addr, pc;
  logic [15:0] imem_data, alu_a, alu_b, alu_c, dmem_wdata, dmem_rdata;
  logic [4:0]  alu_op;
  logic        alu_cf, alu_cout, dmem_req, dmem_we, dmem_ack, halted;
  logic [2:0]  flags;

  my_exec_ctrl #(.ADDR_W(8), .RST_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cf(alu_cf),
    .alu_c(alu_c), .alu_cout(alu_cout),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .flags(flags), .pc(pc), .halted(halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural ALU
  logic [16:0] s;
  always_comb begin
    s = 17'h0;
    case (alu_op)
      ADDC:          s = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_cf};
      SUB, SUBI, CMP:s = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'h1;
      SUBC:          s = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'h0, alu_cf};
      AND_:          s = {1'b0, alu_a & alu_b};
      OR_:           s = {1'b0, alu_a | alu_b};
      XOR_:          s = {1'b0, alu_a ^ alu_b};
      NAND_:         s = {1'b0, ~(alu_a & alu_b)};
      NOR_:          s = {1'b0, ~(alu_a | alu_b)};
      XNOR_:         s = {1'b0, ~(alu_a ^ alu_b)};
      NOT_:          s = {1'b0, ~alu_a};
      SLL, SLA:      s = {1'b0, alu_a << alu_b[3:0]};
      SRL:           s = {1'b0, alu_a >> alu_b[3:0]};
      SRA:           s = {1'b0, 16'($signed(alu_a) >>> alu_b[3:0])};
      NOP, HALT:     s = 17'h0;
      default:       s = {1'b0, alu_a} + {1'b0, alu_b};
    endcase
    alu_c    = s[15:0];
    alu_cout = s[16];
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [7:0]  exp_pc;
    logic [2:0]  exp_fl;
    int          ack_dly;
    logic [15:0] rdata;
    logic [15:0] exp_wd;
  } vec_t;

  localparam int NV = 29;
  vec_t        tv [NV];
  logic [42:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  cur_pc;

  function automatic logic [15:0] rrr(input logic [4:0] o, input logic [2:0] d,
                                      input logic [2:0] x, input logic [3:0] y);
    return {o, d, 1'b0, x, y};
  endfunction
  function automatic logic [15:0] ri(input logic [4:0] o, input logic [2:0] d, input logic [7:0] i);
    return {o, d, i};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // driver: enter at a negedge, leave just after the posedge that accepts the word
  task automatic fetch_word(input logic [15:0] w);
    int t = 0;
    while (!imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("imem_req", 32'(imem_req), 32'd1);
    chk("imem_addr", 32'(imem_addr), 32'(cur_pc));
    repeat ($urandom_range(0, 2)) begin
      imem_data = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("imem_req_hold", 32'(imem_req), 32'd1);
    end
    imem_valid = 1'b1;
    imem_data  = w;
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    imem_data  = 16'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    logic [42:0] e;
    logic [4:0]  o;
    logic [15:0] ea, eb, sum;
    int          cnt;
    o = v.instr[15:11];
    exp_q.push_back({v.exp_a, v.exp_b, v.exp_pc, v.exp_fl});
    fetch_word(v.instr);
    @(posedge clk);
    @(negedge clk);
    e  = exp_q.pop_front();
    ea = e[42:27];
    eb = e[26:11];
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    chk("alu_op", 32'(alu_op), 32'(o));
    if (o == HALT) begin
      @(posedge clk);
      @(negedge clk);
      chk("halted", 32'(halted), 32'd1);
      cnt = 0;
      repeat (10) begin
        imem_valid = 1'b1;
        imem_data  = 16'($urandom);
        @(negedge clk);
        if (imem_req) cnt++;
      end
      imem_valid = 1'b0;
      chk("halt_no_imem_req", 32'(cnt), 32'd0);
      chk("halt_pc", 32'(pc), 32'(e[10:3]));
      chk("halt_flags", 32'(flags), 32'(e[2:0]));
      chk("halted_hold", 32'(halted), 32'd1);
      cur_pc = e[10:3];
      return;
    end
    @(posedge clk);
    if (o == LOAD || o == STORE) begin
      @(negedge clk);
      sum = ea + eb;
      chk("dmem_req", 32'(dmem_req), 32'd1);
      chk("dmem_addr", 32'(dmem_addr), 32'(sum[7:0]));
      chk("dmem_we", 32'(dmem_we), 32'(o == STORE));
      if (o == STORE) chk("dmem_wdata", 32'(dmem_wdata), 32'(v.exp_wd));
      cnt = 0;
      repeat (v.ack_dly) begin
        if (dmem_req) cnt++;
        dmem_rdata = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
      end
      if (dmem_req) cnt++;
      dmem_ack   = 1'b1;
      dmem_rdata = v.rdata;
      @(posedge clk);
      #1;
      dmem_ack   = 1'b0;
      dmem_rdata = 16'($urandom);
      chk("dmem_req_cycles", 32'(cnt), 32'(v.ack_dly + 1));
      @(negedge clk);
      chk("dmem_req_drop", 32'(dmem_req), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("pc", 32'(pc), 32'(e[10:3]));
    chk("flags", 32'(flags), 32'(e[2:0]));
    cur_pc = e[10:3];
  endtask

`ifdef GPR_R0_ZERO_EN
  localparam logic [15:0] R0V  = 16'h0000;
  localparam logic [2:0]  R0FL = 3'b100;
`else
  localparam logic [15:0] R0V  = 16'h0055;
  localparam logic [2:0]  R0FL = 3'b000;
`endif

  initial begin
    tv[0]  = '{ri(LDIL, 3'd1, 8'h34),    16'h0000, 16'h0034, 8'h01, 3'b000, 0, 16'h0, 16'h0};
    tv[1]  = '{ri(LDIH, 3'd1, 8'h12),    16'h0034, 16'h1200, 8'h02, 3'b000, 0, 16'h0, 16'h0};
    tv[2]  = '{ri(ADDI, 3'd1, 8'hFF),    16'h1234, 16'h00FF, 8'h03, 3'b000, 0, 16'h0, 16'h0};
    tv[3]  = '{ri(LDIL, 3'd2, 8'hFF),    16'h0000, 16'h00FF, 8'h04, 3'b000, 0, 16'h0, 16'h0};
    tv[4]  = '{ri(LDIH, 3'd2, 8'hFF),    16'h00FF, 16'hFF00, 8'h05, 3'b000, 0, 16'h0, 16'h0};
    tv[5]  = '{ri(LDIL, 3'd3, 8'h01),    16'h0000, 16'h0001, 8'h06, 3'b000, 0, 16'h0, 16'h0};
    tv[6]  = '{rrr(ADD, 3'd4, 3'd2, 4'd3),  16'hFFFF, 16'h0001, 8'h07, 3'b101, 0, 16'h0, 16'h0};
    tv[7]  = '{rrr(ADDC, 3'd5, 3'd0, 4'd0), 16'h0000, 16'h0000, 8'h08, 3'b000, 0, 16'h0, 16'h0};
    tv[8]  = '{rrr(OR_, 3'd6, 3'd4, 4'd5),  16'h0000, 16'h0001, 8'h09, 3'b000, 0, 16'h0, 16'h0};
    tv[9]  = '{ri(LDIL, 3'd2, 8'h05),    16'h0000, 16'h0005, 8'h0A, 3'b000, 0, 16'h0, 16'h0};
    tv[10] = '{ri(LDIL, 3'd3, 8'h07),    16'h0000, 16'h0007, 8'h0B, 3'b000, 0, 16'h0, 16'h0};
    tv[11] = '{rrr(CMP, 3'd1, 3'd2, 4'd3),  16'h0005, 16'h0007, 8'h0C, 3'b010, 0, 16'h0, 16'h0};
    tv[12] = '{ri(LDIL, 3'd1, 8'h00),    16'h0000, 16'h0000, 8'h0D, 3'b010, 0, 16'h0, 16'h0};
    tv[13] = '{ri(BNN, 3'd1, 8'h20),     16'h0000, 16'h0020, 8'h0E, 3'b010, 0, 16'h0, 16'h0};
    tv[14] = '{ri(BN, 3'd1, 8'h20),      16'h0000, 16'h0020, 8'h20, 3'b010, 0, 16'h0, 16'h0};
    tv[15] = '{ri(LDIL, 3'd1, 8'hEF),    16'h0000, 16'h00EF, 8'h21, 3'b010, 0, 16'h0, 16'h0};
    tv[16] = '{ri(LDIH, 3'd1, 8'hBE),    16'h00EF, 16'hBE00, 8'h22, 3'b010, 0, 16'h0, 16'h0};
    tv[17] = '{ri(LDIL, 3'd2, 8'h04),    16'h0000, 16'h0004, 8'h23, 3'b010, 0, 16'h0, 16'h0};
    tv[18] = '{rrr(STORE, 3'd1, 3'd2, 4'd3), 16'h0004, 16'h0003, 8'h24, 3'b010, 2, 16'h0, 16'hBEEF};
    tv[19] = '{rrr(LOAD, 3'd7, 3'd2, 4'd3),  16'h0004, 16'h0003, 8'h25, 3'b010, 0, 16'hBEEF, 16'h0};
    tv[20] = '{rrr(XOR_, 3'd6, 3'd7, 4'd0), 16'hBEEF, 16'h0000, 8'h26, 3'b010, 0, 16'h0, 16'h0};
    tv[21] = '{rrr(SLL, 3'd6, 3'd7, 4'd4),  16'hBEEF, 16'h0004, 8'h27, 3'b010, 0, 16'h0, 16'h0};
    tv[22] = '{rrr(SUB, 3'd5, 3'd7, 4'd7),  16'hBEEF, 16'hBEEF, 8'h28, 3'b101, 0, 16'h0, 16'h0};
    tv[23] = '{ri(JUMP, 3'd0, 8'hFE),    16'h0000, 16'h00FE, 8'hFE, 3'b101, 0, 16'h0, 16'h0};
    tv[24] = '{{NOP, 11'h000},           16'h0000, 16'h0000, 8'hFF, 3'b101, 0, 16'h0, 16'h0};
    tv[25] = '{{NOP, 11'h000},           16'h0000, 16'h0000, 8'h00, 3'b101, 0, 16'h0, 16'h0};
    tv[26] = '{ri(BNZ, 3'd0, 8'h09),     16'h0000, 16'h0009, 8'h01, 3'b101, 0, 16'h0, 16'h0};
    tv[27] = '{ri(BC, 3'd0, 8'h09),      16'h0000, 16'h0009, 8'h09, 3'b101, 0, 16'h0, 16'h0};
    tv[28] = '{{HALT, 11'h000},          16'h0000, 16'h0000, 8'h09, 3'b101, 0, 16'h0, 16'h0};

    rst        = 1'b1;
    imem_valid = 1'b0;
    imem_data  = 16'h0;
    dmem_ack   = 1'b0;
    dmem_rdata = 16'h0;
    cur_pc     = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b} | 32'(alu_op) | 32'(alu_cf)), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(tv[i]);

    // reset while a data access is pending
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    cur_pc = 8'h00;
    run_vec('{rrr(SUB, 3'd1, 3'd0, 4'd0), 16'h0000, 16'h0000, 8'h01, 3'b101, 0, 16'h0, 16'h0});
    fetch_word(rrr(STORE, 3'd1, 3'd2, 4'd3));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_mem_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_imem_req", 32'(imem_req), 32'd1);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    cur_pc = 8'h00;

    // r0 write/read behaviour
    run_vec('{ri(LDIL, 3'd0, 8'h55), 16'h0000, 16'h0055, 8'h01, 3'b000, 0, 16'h0, 16'h0});
    run_vec('{rrr(OR_, 3'd1, 3'd0, 4'd0), R0V, R0V, 8'h02, R0FL, 0, 16'h0, 16'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
